// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the CNN frame sequencer.
// Constants are the default frame geometry; modules take them as parameter defaults.
package cnn_pkg;

    localparam int unsigned DATA_WIDTH     = 16;
    localparam int unsigned IMAGE_WIDTH    = 188;
    localparam int unsigned IMAGE_HEIGHT   = 120;
    localparam int unsigned IN_CHANNELS    = 4;
    localparam int unsigned NUM_OUTPUTS    = 3;
    localparam int unsigned TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FEED    = 3'd1,
        COLLECT = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4,
        FLUSH   = 3'd5
    } cnn_state_e;

endpackage

// File: rtl/cnn_pixel_fetch.sv
// Frame-BRAM read pipeline: turns CNN pixel requests into single outstanding
// BRAM reads and returns each word as a one-cycle pixel_valid pulse.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           restart the frame (address and count to 0, pipeline emptied)
//   enable          FSM allows reads/deliveries; low discards anything in flight
//   req             CNN pixel request
//   rd_en, addr     BRAM read strobe and address
//   rdata           BRAM read data (valid the cycle after rd_en)
//   pixel, pixel_valid  delivered pixel and its one-cycle strobe
//   count           pixels delivered in this frame
//   ack             a pixel is being delivered at the coming edge (if enabled)
module cnn_pixel_fetch #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TOTAL_PIX  = 8,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  req,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] pixel,
    output logic                  pixel_valid,
    output logic [ADDR_W-1:0]     count,
    output logic                  ack
);

    localparam int unsigned CW = ADDR_W + 1;

    logic          rd_q;
    logic [CW-1:0] committed;
    logic          issue;

    // A read is allowed only when none is outstanding; the word currently
    // returning counts toward the frame so the last read is never overissued.
    always_comb begin
        committed = CW'({1'b0, count}) + CW'(rd_q);
        issue     = req && !rd_en && (committed < CW'(TOTAL_PIX));
    end

    assign ack = rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en       <= 1'b0;
            rd_q        <= 1'b0;
            pixel_valid <= 1'b0;
            pixel       <= '0;
            addr        <= '0;
            count       <= '0;
        end else if (clear) begin
            rd_en       <= 1'b0;
            rd_q        <= 1'b0;
            pixel_valid <= 1'b0;
            addr        <= '0;
            count       <= '0;
        end else if (!enable) begin
            rd_en       <= 1'b0;
            rd_q        <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            rd_en       <= issue;
            rd_q        <= rd_en;
            pixel_valid <= rd_q;
            if (rd_q) begin
                pixel <= rdata;
                addr  <= addr + 1'b1;
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for the CNN accelerator: streams one frame of pixels from
// the frame BRAM into the CNN, collects NUM_OUTPUTS FC results, and guards
// the whole frame with abort and a stall timeout.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, abort                 frame start / cancel pulses
//   bram_rd_en/addr/rdata        frame BRAM read port (1-cycle latency)
//   cnn_enable_pe, cnn_bram_en   CNN enable and its pixel request
//   cnn_pixel, cnn_pixel_valid   pixel stream into the CNN
//   fc_enable, fc_pipe_reset, fc_out_ready, fc_out_valid, fc_out_data  FC control/results
//   results                      captured FC results, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy, done, timeout_err      frame status
//   pix_count                    pixels delivered this frame
module cnn_frame_sequencer #(
    parameter  int unsigned DATA_WIDTH     = cnn_pkg::DATA_WIDTH,
    parameter  int unsigned IMAGE_WIDTH    = cnn_pkg::IMAGE_WIDTH,
    parameter  int unsigned IMAGE_HEIGHT   = cnn_pkg::IMAGE_HEIGHT,
    parameter  int unsigned IN_CHANNELS    = cnn_pkg::IN_CHANNELS,
    parameter  int unsigned NUM_OUTPUTS    = cnn_pkg::NUM_OUTPUTS,
    parameter  int unsigned TIMEOUT_CYCLES = cnn_pkg::TIMEOUT_CYCLES,
    localparam int unsigned TOTAL_PIX      = IMAGE_WIDTH * IMAGE_HEIGHT * IN_CHANNELS,
    localparam int unsigned ADDR_W         = $clog2(TOTAL_PIX + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    output logic                              bram_rd_en,
    output logic [ADDR_W-1:0]                 bram_addr,
    input  logic [DATA_WIDTH-1:0]             bram_rdata,
    output logic                              cnn_enable_pe,
    input  logic                              cnn_bram_en,
    output logic [DATA_WIDTH-1:0]             cnn_pixel,
    output logic                              cnn_pixel_valid,
    output logic                              fc_enable,
    output logic                              fc_pipe_reset,
    output logic                              fc_out_ready,
    input  logic                              fc_out_valid,
    input  logic [DATA_WIDTH-1:0]             fc_out_data,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] results,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout_err,
    output logic [ADDR_W-1:0]                 pix_count
);

    import cnn_pkg::*;

    localparam int unsigned IDX_W   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    cnn_state_e         state, state_next;
    logic [IDX_W-1:0]   idx;
    logic [STALL_W-1:0] stall;
    logic               run, run_next;
    logic               start_frame, capture, stall_hit;
    logic               fetch_enable, fetch_ack;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle decisions; abort overrides everything in a running frame
    always_comb begin
        state_next   = state;
        run          = (state == FEED) || (state == COLLECT);
        start_frame  = ((state == IDLE) || (state == DONE) || (state == ERROR)) && start && !abort;
        capture      = run && fc_out_valid && !abort;
        stall_hit    = run && !abort && !capture && !fetch_ack
                       && (stall == STALL_W'(TIMEOUT_CYCLES - 1));

        case (state)
            IDLE, DONE, ERROR: begin
                if (start_frame) state_next = FEED;
            end
            FEED, COLLECT: begin
                if (abort || stall_hit) begin
                    state_next = FLUSH;
                end else if (capture && (idx == IDX_W'(NUM_OUTPUTS - 1))) begin
                    state_next = DONE;
                end else if ((state == FEED) && (pix_count == ADDR_W'(TOTAL_PIX))) begin
                    state_next = COLLECT;
                end
            end
            FLUSH:   state_next = timeout_err ? ERROR : IDLE;
            default: state_next = IDLE;
        endcase

        run_next     = (state_next == FEED) || (state_next == COLLECT);
        // Reads only while staying in FEED, so leaving FEED drops any read in flight
        fetch_enable = (state == FEED) && (state_next == FEED);
    end

    // Registered outputs, result capture and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnn_enable_pe <= 1'b0;
            fc_enable     <= 1'b0;
            fc_out_ready  <= 1'b0;
            fc_pipe_reset <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            results       <= '0;
            idx           <= '0;
            stall         <= '0;
        end else begin
            cnn_enable_pe <= run_next;
            fc_enable     <= run_next;
            fc_out_ready  <= run_next;
            busy          <= run_next || (state_next == FLUSH);
            done          <= (state_next == DONE);
            fc_pipe_reset <= (state_next == FLUSH);
            if (start_frame) begin
                timeout_err <= 1'b0;
                idx         <= '0;
                stall       <= '0;
            end else begin
                if (stall_hit) timeout_err <= 1'b1;
                if (capture) begin
                    results[int'(idx) * DATA_WIDTH +: DATA_WIDTH] <= fc_out_data;
                    idx <= idx + 1'b1;
                end
                if (run) stall <= (capture || fetch_ack) ? '0 : stall + 1'b1;
            end
        end
    end

    cnn_pixel_fetch #(
        .DATA_WIDTH (DATA_WIDTH),
        .TOTAL_PIX  (TOTAL_PIX),
        .ADDR_W     (ADDR_W)
    ) u_fetch (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_frame),
        .enable      (fetch_enable),
        .req         (cnn_bram_en),
        .rd_en       (bram_rd_en),
        .addr        (bram_addr),
        .rdata       (bram_rdata),
        .pixel       (cnn_pixel),
        .pixel_valid (cnn_pixel_valid),
        .count       (pix_count),
        .ack         (fetch_ack)
    );

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer on a 4x2x1 frame with 3 FC outputs.
module tb_cnn_frame_sequencer;
    import cnn_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned NO = 3;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst, start, abort, cnn_bram_en, fc_out_valid;
    logic bram_rd_en, cnn_enable_pe, cnn_pixel_valid, fc_enable, fc_pipe_reset, fc_out_ready;
    logic busy, done, timeout_err;
    logic [AW-1:0]    bram_addr, pix_count;
    logic [DW-1:0]    bram_rdata = '0;
    logic [DW-1:0]    cnn_pixel, fc_out_data;
    logic [NO*DW-1:0] results;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int pix_n, rd_n, bad_rd, bad_addr, gap_bad, last_pix_cyc, pipe_rst_n;
    bit chk_gap;

    cnn_frame_sequencer #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .IN_CHANNELS(1),
        .NUM_OUTPUTS(NO), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bram_rd_en(bram_rd_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
        .cnn_enable_pe(cnn_enable_pe), .cnn_bram_en(cnn_bram_en),
        .cnn_pixel(cnn_pixel), .cnn_pixel_valid(cnn_pixel_valid),
        .fc_enable(fc_enable), .fc_pipe_reset(fc_pipe_reset), .fc_out_ready(fc_out_ready),
        .fc_out_valid(fc_out_valid), .fc_out_data(fc_out_data),
        .results(results), .busy(busy), .done(done), .timeout_err(timeout_err),
        .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    // Frame BRAM: word i holds 0x0100 + i, one-cycle read latency
    always @(posedge clk) begin
        if (bram_rd_en) bram_rdata <= DW'(32'h0100 + 32'(bram_addr));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        pix_n = 0; rd_n = 0; bad_rd = 0; bad_addr = 0;
        gap_bad = 0; last_pix_cyc = 0; pipe_rst_n = 0;
    endtask

    // Called once per cycle, 1 ns after the edge, before inputs change
    task automatic observe();
        cyc++;
        if (bram_rd_en) begin
            if (!cnn_bram_en) bad_rd++;
            if (int'(bram_addr) != rd_n) bad_addr++;
            rd_n++;
        end
        if (cnn_pixel_valid) begin
            check("pix_data", 64'(cnn_pixel), 64'(32'h0100 + pix_n));
            if (chk_gap && pix_n > 0 && (cyc - last_pix_cyc) != 2) gap_bad++;
            last_pix_cyc = cyc;
            pix_n++;
        end
        if (fc_pipe_reset) pipe_rst_n++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        observe();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cnn_bram_en = 1'b0;
        fc_out_valid = 1'b0; fc_out_data = '0; chk_gap = 1'b0;
        clear_mon();
        step(); step();
        check("rst_ctrl", 64'({busy, done, timeout_err, cnn_enable_pe, fc_enable, fc_out_ready,
                               bram_rd_en, cnn_pixel_valid, fc_pipe_reset}), 64'(0));
        check("rst_data", 64'({bram_addr, pix_count, cnn_pixel}), 64'(0));
        check("rst_results", 64'(results), 64'(0));
        rst = 1'b0;
        step();
        check("idle_state", 64'(dut.state), 64'(IDLE));

        // Held request: 8 pixels, one every other cycle
        clear_mon(); chk_gap = 1'b1; cnn_bram_en = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        check("feed_busy", 64'(busy), 64'(1));
        check("feed_enables", 64'({cnn_enable_pe, fc_enable, fc_out_ready}), 64'(3'b111));
        check("feed_pix0", 64'(pix_count), 64'(0));
        for (int i = 0; i < 40 && pix_n < 8; i++) step();
        step(); step();
        check("a_pix_n", 64'(pix_n), 64'(8));
        check("a_rd_n", 64'(rd_n), 64'(8));
        check("a_pix_count", 64'(pix_count), 64'(8));
        check("a_state", 64'(dut.state), 64'(COLLECT));
        check("a_gap", 64'(gap_bad), 64'(0));
        check("a_addr_order", 64'(bad_addr), 64'(0));
        check("a_bad_rd", 64'(bad_rd), 64'(0));
        check("a_collect_en", 64'({cnn_enable_pe, fc_enable}), 64'(2'b11));
        start = 1'b1; step(); start = 1'b0;
        check("a_start_ignored", 64'(dut.state), 64'(COLLECT));
        check("a_count_kept", 64'(pix_count), 64'(8));

        // FC results: three captured, fourth ignored
        fc_out_valid = 1'b1; fc_out_data = 16'h0011; step();
        fc_out_data = 16'h0022; step();
        check("b_not_done", 64'(done), 64'(0));
        fc_out_data = 16'h0033; step();
        check("b_done", 64'(done), 64'(1));
        fc_out_data = 16'h0044; step();
        fc_out_valid = 1'b0; step();
        check("b_results", 64'(results), 64'(48'h0033_0022_0011));
        check("b_done_quiet", 64'({busy, cnn_enable_pe, fc_enable, fc_out_ready}), 64'(0));
        check("b_done_sticky", 64'(done), 64'(1));

        // Random request pattern
        clear_mon(); chk_gap = 1'b0; cnn_bram_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check("c_done_cleared", 64'(done), 64'(0));
        for (int i = 0; i < 300 && pix_n < 8; i++) begin
            cnn_bram_en = 1'($urandom_range(0, 1));
            step();
        end
        cnn_bram_en = 1'b0;
        step(); step();
        check("c_pix_n", 64'(pix_n), 64'(8));
        check("c_rd_n", 64'(rd_n), 64'(8));
        check("c_bad_rd", 64'(bad_rd), 64'(0));
        check("c_addr_order", 64'(bad_addr), 64'(0));
        check("c_pix_count", 64'(pix_count), 64'(8));
        check("c_results_held", 64'(results), 64'(48'h0033_0022_0011));
        abort = 1'b1; step(); abort = 1'b0;
        check("c_flush", 64'({fc_pipe_reset, busy, cnn_enable_pe}), 64'(3'b110));
        step();
        check("c_idle", 64'(dut.state), 64'(IDLE));
        check("c_no_to", 64'(timeout_err), 64'(0));

        // No requests: stall timeout
        clear_mon(); cnn_bram_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 49; i++) step();
        check("d_no_to_yet", 64'(timeout_err), 64'(0));
        check("d_busy_yet", 64'(busy), 64'(1));
        step();
        check("d_timeout", 64'(timeout_err), 64'(1));
        check("d_flush_pulse", 64'(fc_pipe_reset), 64'(1));
        check("d_flush_state", 64'(dut.state), 64'(FLUSH));
        step();
        check("d_err_state", 64'(dut.state), 64'(ERROR));
        check("d_err_busy", 64'(busy), 64'(0));
        check("d_err_sticky", 64'(timeout_err), 64'(1));
        step(); step();
        check("d_pipe_rst_once", 64'(pipe_rst_n), 64'(1));
        check("d_no_reads", 64'(rd_n), 64'(0));

        // Abort with simultaneous start at pix_count 3
        clear_mon(); cnn_bram_en = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        check("e_to_cleared", 64'(timeout_err), 64'(0));
        for (int i = 0; i < 40 && pix_count != 4'd3; i++) step();
        check("e_at3", 64'(pix_count), 64'(3));
        abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
        check("e_flush_state", 64'(dut.state), 64'(FLUSH));
        check("e_flush_out", 64'({fc_pipe_reset, busy, cnn_enable_pe, fc_enable, bram_rd_en}),
              64'(5'b11000));
        step();
        check("e_idle", 64'(dut.state), 64'(IDLE));
        check("e_no_to", 64'(timeout_err), 64'(0));
        step(); step();
        check("e_no_extra_pix", 64'(pix_n), 64'(3));

        clear_mon(); chk_gap = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        check("e_restart_pix", 64'(pix_count), 64'(0));
        for (int i = 0; i < 40 && pix_count != 4'd5; i++) step();
        check("e_restart_addr", 64'(bad_addr), 64'(0));
        check("f_at5", 64'(pix_count), 64'(5));

        // Reset mid-frame
        rst = 1'b1; step();
        check("f_rst_ctrl", 64'({busy, done, timeout_err, cnn_enable_pe, fc_enable, fc_out_ready,
                                 bram_rd_en, cnn_pixel_valid, fc_pipe_reset}), 64'(0));
        check("f_rst_data", 64'({bram_addr, pix_count, cnn_pixel}), 64'(0));
        check("f_rst_results", 64'(results), 64'(0));
        check("f_rst_state", 64'(dut.state), 64'(IDLE));
        rst = 1'b0;
        step(); step();
        check("f_no_pipe_rst", 64'(pipe_rst_n), 64'(0));
        check("f_quiet", 64'({busy, bram_rd_en, cnn_pixel_valid}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
